// File: rtl/bit_error_injector.sv
// rtl/bit_error_injector.sv - flips exactly k LFSR-chosen bits of a byte (optional seed port via SEED_LOAD_EN)
module bit_error_injector (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic [3:0] in_weight,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic [7:0] out_mask
`ifdef SEED_LOAD_EN
    ,
    input  logic       seed_valid,
    input  logic [7:0] seed_in
`endif
);

    localparam logic [7:0] SEED_DEFAULT = 8'hA5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUILD = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t     state, state_next;
    logic [7:0] ref_data;
    logic [3:0] weight;
    logic [7:0] mask;
    logic [3:0] count;
    logic [7:0] lfsr;

    logic [2:0] idx;
    logic [7:0] hit_mask;
    logic [3:0] hit_count;
    logic       done;
    logic [3:0] weight_clamped;
    logic [7:0] lfsr_step;
    logic       fire;

    always_comb begin
        in_ready       = (state == IDLE);
        out_valid      = (state == HOLD);
        fire           = in_valid && (state == IDLE);
        weight_clamped = (in_weight > 4'd8) ? 4'd8 : in_weight;
        idx            = lfsr[2:0];
        hit_mask       = mask | (8'd1 << idx);
        hit_count      = count + {3'b000, ~mask[idx]};
        done           = (hit_count == weight);
        lfsr_step      = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        state_next     = state;
        case (state)
            IDLE: begin
                if (fire) state_next = (weight_clamped == 4'd0) ? HOLD : BUILD;
            end
            BUILD: begin
                if (done) state_next = HOLD;
            end
            HOLD: begin
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_data <= 8'h00;
            weight   <= 4'd0;
            mask     <= 8'h00;
            count    <= 4'd0;
            lfsr     <= SEED_DEFAULT;
            out_data <= 8'h00;
            out_mask <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
`ifdef SEED_LOAD_EN
                    // A zero seed would lock the LFSR, so it maps to the default.
                    if (seed_valid) lfsr <= (seed_in == 8'h00) ? SEED_DEFAULT : seed_in;
`endif
                    if (fire) begin
                        ref_data <= in_data;
                        weight   <= weight_clamped;
                        mask     <= 8'h00;
                        count    <= 4'd0;
                        if (weight_clamped == 4'd0) begin
                            out_data <= in_data;
                            out_mask <= 8'h00;
                        end
                    end
                end
                BUILD: begin
                    mask  <= hit_mask;
                    count <= hit_count;
                    lfsr  <= lfsr_step;
                    if (done) begin
                        out_mask <= hit_mask;
                        out_data <= ref_data ^ hit_mask;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit_error_injector.sv
// tb/tb_bit_error_injector.sv - directed self-checking bench for bit_error_injector
module tb_bit_error_injector;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [3:0] in_weight;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [7:0] out_mask;
`ifdef SEED_LOAD_EN
    logic       seed_valid;
    logic [7:0] seed_in;
`endif

    int checks = 0;
    int errors = 0;
    int lat;
    logic [7:0] held_data, held_mask;

    bit_error_injector dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_weight (in_weight),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_mask  (out_mask)
`ifdef SEED_LOAD_EN
        ,
        .seed_valid(seed_valid),
        .seed_in   (seed_in)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] popcount(input logic [7:0] v);
        logic [1:0] s0, s1, s2, s3;
        logic [2:0] t0, t1;
        s0 = {1'b0, v[0]} + {1'b0, v[1]};
        s1 = {1'b0, v[2]} + {1'b0, v[3]};
        s2 = {1'b0, v[4]} + {1'b0, v[5]};
        s3 = {1'b0, v[6]} + {1'b0, v[7]};
        t0 = {1'b0, s0} + {1'b0, s1};
        t1 = {1'b0, s2} + {1'b0, s3};
        return {1'b0, t0} + {1'b0, t1};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one request and returns the cycles from handshake edge to out_valid.
    task automatic request(input logic [7:0] a, input logic [3:0] k, output int cycles);
        in_data   = a;
        in_weight = k;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        cycles = 1;
        while (!out_valid && cycles < 400) begin
            tick();
            cycles++;
        end
        if (cycles >= 400) check("timeout", 32'(cycles), 32'd0);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("consume_valid", 32'(out_valid), 32'd0);
        check("consume_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_weight = 4'd0;
        out_ready = 1'b0;
`ifdef SEED_LOAD_EN
        seed_valid = 1'b0;
        seed_in    = 8'h00;
`endif
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'h00);
        check("rst_out_mask", 32'(out_mask), 32'h00);
        rst = 1'b0;
        tick();

        request(8'hAA, 4'd0, lat);
        check("k0_latency", 32'(lat), 32'd1);
        check("k0_data", 32'(out_data), 32'hAA);
        check("k0_mask", 32'(out_mask), 32'h00);
        check("k0_in_ready", 32'(in_ready), 32'd0);
        consume();

        request(8'hAA, 4'd8, lat);
        check("k8_data", 32'(out_data), 32'h55);
        check("k8_mask", 32'(out_mask), 32'hFF);
        check("k8_build_max", 32'(lat - 1 <= 255), 32'd1);
        check("k8_build_min", 32'(lat >= 9), 32'd1);
        consume();

        out_ready = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            request(8'hAA, 4'(k), lat);
            check("sweep_popcount_mask", 32'(popcount(out_mask)), 32'(k));
            check("sweep_popcount_diff", 32'(popcount(out_data ^ 8'hAA)), 32'(k));
            check("sweep_data", 32'(out_data), 32'(8'hAA ^ out_mask));
            check("sweep_latency", 32'(lat >= k + 1), 32'd1);
            tick();
            check("sweep_back_idle", 32'(in_ready), 32'd1);
        end
        out_ready = 1'b0;

        request(8'hAA, 4'd4, lat);
        check("hold_popcount", 32'(popcount(out_mask)), 32'd4);
        held_data = out_data;
        held_mask = out_mask;
        in_valid  = 1'b1;
        in_data   = 8'h12;
        in_weight = 4'd1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_data", 32'(out_data), 32'(held_data));
            check("hold_mask", 32'(out_mask), 32'(held_mask));
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        consume();
        check("hold_data_kept", 32'(out_data), 32'(held_data));

        request(8'hAA, 4'd12, lat);
        check("clamp_mask", 32'(out_mask), 32'hFF);
        check("clamp_data", 32'(out_data), 32'h55);
        consume();

        in_data   = 8'hAA;
        in_weight = 4'd8;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check("midbuild_ready", 32'(in_ready), 32'd0);
        rst = 1'b1;
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_ready", 32'(in_ready), 32'd1);
        check("midrst_mask", 32'(out_mask), 32'h00);
        tick();
        rst = 1'b0;
        // From seed A5 the index walk is 5,2,5,2,4.
        request(8'hAA, 4'd3, lat);
        check("postrst_k3_mask", 32'(out_mask), 32'h34);
        check("postrst_k3_data", 32'(out_data), 32'h9E);
        check("postrst_k3_latency", 32'(lat), 32'd6);
        consume();

`ifdef SEED_LOAD_EN
        do_reset();
        seed_in    = 8'h00;
        seed_valid = 1'b1;
        request(8'h0F, 4'd2, lat);
        seed_valid = 1'b0;
        check("seed0_mask", 32'(out_mask), 32'h24);
        check("seed0_data", 32'(out_data), 32'h2B);
        consume();
        seed_in    = 8'h3C;
        seed_valid = 1'b1;
        tick();
        seed_valid = 1'b0;
        request(8'h0F, 4'd2, lat);
        check("seed3c_popcount", 32'(popcount(out_mask)), 32'd2);
        check("seed3c_mask", 32'(out_mask), 32'h12);
        check("seed3c_data", 32'(out_data), 32'h1D);
        consume();
`else
        do_reset();
        request(8'h0F, 4'd2, lat);
        check("default_seed_k2_mask", 32'(out_mask), 32'h24);
        check("default_seed_k2_data", 32'(out_data), 32'h2B);
        consume();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bit_error_injector.md
BIT_ERROR_INJECTOR -- requirements
Module: bit_error_injector

Interface
REQ-001 SHALL have one clock and one reset: reset is asynchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 in_valid  input  1  request present.
REQ-005 in_ready  output  1  block accepts request this cycle.
REQ-006 in_data  input  8  reference byte a.
REQ-007 in_weight  input  4  required Hamming distance k; values above 8 are treated as 8.
REQ-008 out_valid  output  1  corrupted byte available.
REQ-009 out_ready  input  1  consumer takes result.
REQ-010 out_data  output  8  b = a XOR mask.
REQ-011 out_mask  output  8  flip mask; popcount(out_mask) == k.

Function
REQ-012 SHALL implement FSM states IDLE, BUILD, HOLD.
REQ-013 in_ready SHALL be 1 only in IDLE; the handshake fires on in_valid & in_ready at a rising clk edge.
REQ-014 On handshake, the block SHALL latch in_data and min(in_weight,8), clear mask and count, and enter BUILD; if k==0 it SHALL enter HOLD directly.
REQ-015 BUILD SHALL do the following each cycle: idx = lfsr[2:0]; if mask[idx]==0, set mask[idx] and increment count; LFSR advances one step.
REQ-016 The LFSR SHALL be 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, and advance only in BUILD.
REQ-017 BUILD SHALL exit to HOLD on the edge where count reaches k; that edge is the same edge on which the final mask bit is set.
REQ-018 BUILD SHALL never exceed 255 cycles; the maximal-length LFSR guarantees all 8 indices occur.
REQ-019 In HOLD, out_valid SHALL be 1 and out_data/out_mask SHALL be stable until out_valid & out_ready at an edge; the block then returns to IDLE.
REQ-020 out_valid SHALL be 0 in IDLE and BUILD; out_data/out_mask SHALL hold their last values outside HOLD.
REQ-021 Minimum request-to-out_valid latency SHALL be 1 cycle for k=0 and at least k+1 cycles for k>0.
REQ-022 out_ready asserted while not in HOLD SHALL have no effect; in_valid outside IDLE SHALL be ignored and no request is dropped silently, because in_ready=0.
REQ-023 Every result SHALL satisfy popcount(out_data XOR latched in_data) == k; k=8 gives ~a.

Reset
REQ-024 rst asserted at any time, including mid-BUILD or in HOLD, SHALL immediately force IDLE, in_ready=1, out_valid=0, out_data=0, out_mask=0, count=0, and LFSR=8'hA5.
REQ-025 A request interrupted by reset SHALL be discarded with no partial output.

Configuration
REQ-026 Macro SEED_LOAD_EN, when defined, SHALL add the ports seed_valid (input 1) and seed_in (input 8).
REQ-027 With SEED_LOAD_EN defined, seed_valid in IDLE SHALL load the LFSR at the next edge; seed_in==0 SHALL load 8'hA5 instead, avoiding lock-up.
REQ-028 With SEED_LOAD_EN defined, seed_valid outside IDLE SHALL be ignored, and seed_valid together with an in_valid handshake SHALL load the seed before BUILD starts.
REQ-029 With SEED_LOAD_EN undefined, the seed ports SHALL be absent and the LFSR seed SHALL be fixed at 8'hA5 from reset only.

Verification
REQ-030 Bench SHALL cover: reset, then a=8'hAA, k=0 -> out_valid after 1 cycle, out_data=8'hAA, out_mask=8'h00.
REQ-031 Bench SHALL cover: a=8'hAA, k=8 -> out_data=8'h55, out_mask=8'hFF, BUILD lasts at most 255 cycles.
REQ-032 Bench SHALL cover: a=8'hAA with k=1..7 swept and out_ready=1 -> for each case, popcount(out_mask)==k and out_data==8'hAA^out_mask; the bench checks this by recomputing the mismatch count of a vs b with its adder-tree reference.
REQ-033 Bench SHALL cover: k=4 with out_ready held 0 for 10 cycles -> out_valid stays 1, outputs stable, in_ready=0; out_ready=1 -> IDLE next cycle.
REQ-034 Bench SHALL cover: k=8 with rst pulsed mid-BUILD -> out_valid=0, in_ready=1 immediately; the next request with k=3 yields the same mask as a fresh post-reset run.
REQ-035 Bench SHALL cover, with SEED_LOAD_EN: seed_in=8'h00 then a=8'h0F, k=2 -> mask identical to the default-seed run; seed_in=8'h3C -> valid weight-2 mask.
